// File: rtl/surf_scale_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// surf_scale_scheduler : runs the determinant engine once per octave/layer pass.
// Optional per-pass watchdog: SURF_SCHED_TIMEOUT_EN.  Revision: 1.0
// ----------------------------------------------------------------------------
module surf_scale_scheduler #(
   parameter int A_WIDTH        = 17,
   parameter int NUM_OCT        = 2,
   parameter int LAYER_WORDS    = 16384,
   parameter int TIMEOUT_CYCLES = 1048576
) (
   input  logic               Clk,
   input  logic               Rst,
   input  logic               Start,
   input  logic               Abort,
   input  logic               Det_Done,
   output logic               Det_Go,
   output logic [7:0]         Filter_Size,
   output logic [2:0]         Step,
   output logic [1:0]         Octave,
   output logic [1:0]         Layer,
   output logic [A_WIDTH-1:0] Res_Base,
   output logic               Busy,
   output logic               Done,
   output logic               Error
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_GO    = 3'd2,
      S_WAIT  = 3'd3,
      S_NEXT  = 3'd4,
      S_FIN   = 3'd5
   } state_t;

   localparam logic [1:0]         c_LAST_OCT    = 2'(NUM_OCT - 1);
   localparam logic [A_WIDTH-1:0] c_LAYER_WORDS = A_WIDTH'(LAYER_WORDS);

   state_t               r_state;
   logic                 r_done_prev;
   logic                 r_det_go;
   logic                 r_busy;
   logic                 r_done;
   logic [1:0]           r_oct;
   logic [1:0]           r_layer;
   logic [7:0]           r_fs;
   logic [2:0]           r_step;
   logic [A_WIDTH-1:0]   r_base;

   logic                 w_done_rise;
   logic                 w_timeout;
   logic [7:0]           w_fs;
   logic [2:0]           w_step;
   logic [A_WIDTH-1:0]   w_base;

   assign w_done_rise = Det_Done & ~r_done_prev;

   // Filter side 3*(2^(o+1)*(l+1)+1) peaks at 195, so 8-bit arithmetic never overflows.
   assign w_fs   = 8'd3 * (((8'd2 << r_oct) * (8'({2'b00, r_layer}) + 8'd1)) + 8'd1);
   assign w_step = 3'd1 << r_oct;
   assign w_base = A_WIDTH'({r_oct, r_layer}) * c_LAYER_WORDS;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_state     <= S_IDLE;
         r_done_prev <= 1'b0;
         r_det_go    <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_oct       <= 2'd0;
         r_layer     <= 2'd0;
         r_fs        <= 8'd9;
         r_step      <= 3'd1;
         r_base      <= '0;
      end else begin
         r_done_prev <= Det_Done;
         r_det_go    <= 1'b0;
         r_done      <= 1'b0;
         if (Abort && (r_state != S_IDLE)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (Start && !Abort) begin
                     r_state <= S_SETUP;
                     r_oct   <= 2'd0;
                     r_layer <= 2'd0;
                     r_busy  <= 1'b1;
                  end
               end
               S_SETUP: begin
                  r_fs     <= w_fs;
                  r_step   <= w_step;
                  r_base   <= w_base;
                  r_det_go <= 1'b1;
                  r_state  <= S_GO;
               end
               S_GO: r_state <= S_WAIT;
               S_WAIT: begin
                  if (w_done_rise) begin
                     r_state <= S_NEXT;
                  end else if (w_timeout) begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end
               end
               S_NEXT: begin
                  if (r_layer != 2'd3) begin
                     r_layer <= r_layer + 2'd1;
                     r_state <= S_SETUP;
                  end else if (r_oct < c_LAST_OCT) begin
                     r_layer <= 2'd0;
                     r_oct   <= r_oct + 2'd1;
                     r_state <= S_SETUP;
                  end else begin
                     r_state <= S_FIN;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end
               end
               S_FIN: r_state <= S_IDLE;
               default: begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

`ifdef SURF_SCHED_TIMEOUT_EN
   localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [c_CNT_W-1:0] r_wd_cnt;
   logic               r_error;

   assign w_timeout = (r_wd_cnt == c_CNT_W'(TIMEOUT_CYCLES - 1));
   assign Error     = r_error;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_wd_cnt <= '0;
         r_error  <= 1'b0;
      end else begin
         if (r_state == S_GO) begin
            r_wd_cnt <= '0;
         end else if (r_state == S_WAIT) begin
            r_wd_cnt <= r_wd_cnt + c_CNT_W'(1);
         end
         // A completion edge in the final watchdog cycle still wins over the error.
         if ((r_state == S_IDLE) && Start && !Abort) begin
            r_error <= 1'b0;
         end else if ((r_state == S_WAIT) && w_timeout && !Abort && !w_done_rise) begin
            r_error <= 1'b1;
         end
      end
   end
`else
   assign w_timeout = 1'b0;
   assign Error     = 1'b0;
`endif

   assign Det_Go      = r_det_go;
   assign Filter_Size = r_fs;
   assign Step        = r_step;
   assign Octave      = r_oct;
   assign Layer       = r_layer;
   assign Res_Base    = r_base;
   assign Busy        = r_busy;
   assign Done        = r_done;

endmodule
`default_nettype wire
